// File: rtl/dram_stream_packer_pkg.sv
// Shared types and width helpers for the DRAM stream packer.
// Holds the FSM state encoding and the integer helpers used for parameter sizing.
package dram_stream_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/dram_stream_packer_accum.sv
// Beat accumulator: shifts narrow beats into a wide word, MSB-first, and counts beats.
// Presents either the word completed by the incoming beat or the pending beats left-aligned.
module dram_stream_packer_accum
  import dram_stream_packer_pkg::*;
#(
  parameter  int IN    = 8,
  parameter  int OUT   = 163,
  localparam int BEATS = ceil_div(OUT, IN),
  localparam int ACCU  = BEATS * IN,
  localparam int CNT_W = clog2_min1(BEATS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           load,
  input  logic           pad,
  input  logic [IN-1:0]  data,
  output logic [OUT-1:0] word,
  output logic           last,
  output logic           pending
);

  logic [ACCU-1:0]  acc_q;
  logic [ACCU-1:0]  shifted;
  logic [ACCU-1:0]  padded;
  logic [ACCU-1:0]  sel;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    shifted = (acc_q << IN) | ACCU'(data);
    // Pending beats sit in the LSBs; pushing them up leaves zero padding below.
    padded  = acc_q << ((BEATS - int'(cnt_q)) * IN);
    sel     = pad ? padded : shifted;
    word    = OUT'(sel >> (ACCU - OUT));
  end

  assign last    = (cnt_q == CNT_W'(BEATS - 1));
  assign pending = (cnt_q != '0);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear || pad) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      if (last) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= shifted;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dram_stream_packer.sv
// Packs a narrow valid/ready DRAM beat stream into wide words written round-robin
// across NUM_BANKS BRAMs, with partial-word flush and a done flag once all banks are full.
module dram_stream_packer
  import dram_stream_packer_pkg::*;
#(
  parameter  int DATA_IN_BITWIDTH  = 8,
  parameter  int DATA_OUT_BITWIDTH = 163,
  parameter  int NUM_BANKS         = 4,
  parameter  int BANK_DEPTH        = 512,
  localparam int ADDR_BITWIDTH     = $clog2(BANK_DEPTH),
  localparam int BANK_BITWIDTH     = clog2_min1(NUM_BANKS)
) (
  input  logic                         clk_i,
  input  logic                         dram_pack_rst_ni,
  input  logic                         start_i,
  input  logic                         flush_i,
  input  logic [DATA_IN_BITWIDTH-1:0]  data_in_i,
  input  logic                         data_valid_i,
  output logic                         data_ready_o,
  output logic [DATA_OUT_BITWIDTH-1:0] mem_data_o,
  output logic [ADDR_BITWIDTH-1:0]     mem_addr_o,
  output logic [NUM_BANKS-1:0]         mem_we_o,
  output logic                         done_o
);

  state_e                       state_q, state_d;
  logic [BANK_BITWIDTH-1:0]     bank_q;
  logic [ADDR_BITWIDTH-1:0]     addr_q;
  logic [DATA_OUT_BITWIDTH-1:0] acc_word;
  logic                         acc_last, acc_pending;
  logic                         accept, complete, flush_go, write_issue, final_slot, restart;

  assign data_ready_o = (state_q == ST_FILL);
  assign accept       = data_valid_i && data_ready_o;
  assign complete     = accept && acc_last;
  // A beat accepted alongside flush_i joins the word first; a completed word makes the flush moot.
  assign flush_go     = (state_q == ST_FILL) && flush_i && !complete && (acc_pending || accept);
  assign write_issue  = complete || (state_q == ST_FLUSH);
  assign restart      = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign final_slot   = (bank_q == BANK_BITWIDTH'(NUM_BANKS - 1)) &&
                        (addr_q == ADDR_BITWIDTH'(BANK_DEPTH - 1));

  dram_stream_packer_accum #(
    .IN  (DATA_IN_BITWIDTH),
    .OUT (DATA_OUT_BITWIDTH)
  ) u_accum (
    .clk     (clk_i),
    .rst_n   (dram_pack_rst_ni),
    .clear   (restart),
    .load    (accept),
    .pad     (state_q == ST_FLUSH),
    .data    (data_in_i),
    .word    (acc_word),
    .last    (acc_last),
    .pending (acc_pending)
  );

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FILL;
      ST_FILL: begin
        if (write_issue && final_slot) state_d = ST_DONE;
        else if (flush_go)             state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = final_slot ? ST_DONE : ST_FILL;
      ST_DONE:  if (start_i) state_d = ST_FILL;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge dram_pack_rst_ni) begin
    if (!dram_pack_rst_ni) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      mem_data_o <= '0;
      mem_addr_o <= '0;
      mem_we_o   <= '0;
      done_o     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_o <= '0;
      done_o   <= (state_q == ST_DONE) && !start_i;
      if (restart) begin
        bank_q <= '0;
        addr_q <= '0;
      end
      if (write_issue) begin
        mem_we_o   <= NUM_BANKS'(1) << bank_q;
        mem_data_o <= acc_word;
        mem_addr_o <= addr_q;
        if (bank_q == BANK_BITWIDTH'(NUM_BANKS - 1)) begin
          bank_q <= '0;
          addr_q <= addr_q + ADDR_BITWIDTH'(1);
        end else begin
          bank_q <= bank_q + BANK_BITWIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_stream_packer.sv
// Directed and randomized checks of dram_stream_packer on a small (20-bit, 2x2) and a
// wide (163-bit, 4x4) instance against a beat-list reference model.
module tb_dram_stream_packer;

  localparam int IN      = 8;
  localparam int OUT_S   = 20;
  localparam int NB_S    = 2;
  localparam int BD_S    = 2;
  localparam int BEATS_S = 3;
  localparam int OUT_W   = 163;
  localparam int NB_W    = 4;
  localparam int BD_W    = 4;
  localparam int BEATS_W = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_s, flush_s, valid_s, ready_s, done_s;
  logic [IN-1:0]    din_s;
  logic [OUT_S-1:0] data_s;
  logic [0:0]       addr_s;
  logic [NB_S-1:0]  we_s;

  logic             start_w, flush_w, valid_w, ready_w, done_w;
  logic [IN-1:0]    din_w;
  logic [OUT_W-1:0] data_w;
  logic [1:0]       addr_w;
  logic [NB_W-1:0]  we_w;

  dram_stream_packer #(.DATA_IN_BITWIDTH(IN), .DATA_OUT_BITWIDTH(OUT_S),
                       .NUM_BANKS(NB_S), .BANK_DEPTH(BD_S)) dut_s (
    .clk_i(clk), .dram_pack_rst_ni(rst_n), .start_i(start_s), .flush_i(flush_s),
    .data_in_i(din_s), .data_valid_i(valid_s), .data_ready_o(ready_s),
    .mem_data_o(data_s), .mem_addr_o(addr_s), .mem_we_o(we_s), .done_o(done_s));

  dram_stream_packer #(.DATA_IN_BITWIDTH(IN), .DATA_OUT_BITWIDTH(OUT_W),
                       .NUM_BANKS(NB_W), .BANK_DEPTH(BD_W)) dut_w (
    .clk_i(clk), .dram_pack_rst_ni(rst_n), .start_i(start_w), .flush_i(flush_w),
    .data_in_i(din_w), .data_valid_i(valid_w), .data_ready_o(ready_w),
    .mem_data_o(data_w), .mem_addr_o(addr_w), .mem_we_o(we_w), .done_o(done_w));

  typedef struct {
    logic [7:0]   we;
    logic [15:0]  addr;
    logic [255:0] data;
  } wr_t;

  wr_t        obs_s[$], exp_s[$], obs_w[$], exp_w[$];
  logic [7:0] pend_s[$], pend_w[$];
  int         nwr_s, nwr_w;
  int         errors = 0;
  int         checks = 0;

  always @(negedge clk) begin
    if (we_s != '0) obs_s.push_back('{we: 8'(we_s), addr: 16'(addr_s), data: 256'(data_s)});
    if (we_w != '0) obs_w.push_back('{we: 8'(we_w), addr: 16'(addr_w), data: 256'(data_w)});
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Concatenate the beats MSB-first, zero-fill missing beats, keep the top outw bits.
  function automatic logic [255:0] pack(input logic [7:0] b[$], input int beats, input int outw);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < beats; i++)
      v = (v << IN) | ((i < b.size()) ? 256'(b[i]) : 256'(0));
    return v >> (beats * IN - outw);
  endfunction

  task automatic expect_write(input int id, input logic [255:0] word);
    wr_t e;
    if (id == 0) begin
      e = '{we: 8'(1 << (nwr_s % NB_S)), addr: 16'(nwr_s / NB_S), data: word};
      nwr_s++;
      exp_s.push_back(e);
    end else begin
      e = '{we: 8'(1 << (nwr_w % NB_W)), addr: 16'(nwr_w / NB_W), data: word};
      nwr_w++;
      exp_w.push_back(e);
    end
  endtask

  task automatic model_beat(input int id, input logic [7:0] b);
    if (id == 0) begin
      pend_s.push_back(b);
      if (pend_s.size() == BEATS_S) begin
        expect_write(0, pack(pend_s, BEATS_S, OUT_S));
        pend_s.delete();
      end
    end else begin
      pend_w.push_back(b);
      if (pend_w.size() == BEATS_W) begin
        expect_write(1, pack(pend_w, BEATS_W, OUT_W));
        pend_w.delete();
      end
    end
  endtask

  task automatic model_flush_s();
    if (pend_s.size() > 0) begin
      expect_write(0, pack(pend_s, BEATS_S, OUT_S));
      pend_s.delete();
    end
  endtask

  task automatic drain(input int id, input string tag);
    wr_t o, e;
    if (id == 0) begin
      check({tag, "_count"}, 256'(obs_s.size()), 256'(exp_s.size()));
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
        o = obs_s.pop_front();
        e = exp_s.pop_front();
        check({tag, "_we"}, 256'(o.we), 256'(e.we));
        check({tag, "_addr"}, 256'(o.addr), 256'(e.addr));
        check({tag, "_data"}, o.data, e.data);
      end
      obs_s.delete();
      exp_s.delete();
    end else begin
      check({tag, "_count"}, 256'(obs_w.size()), 256'(exp_w.size()));
      while (obs_w.size() > 0 && exp_w.size() > 0) begin
        o = obs_w.pop_front();
        e = exp_w.pop_front();
        check({tag, "_we"}, 256'(o.we), 256'(e.we));
        check({tag, "_addr"}, 256'(o.addr), 256'(e.addr));
        check({tag, "_data"}, o.data, e.data);
      end
      obs_w.delete();
      exp_w.delete();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_s_pulse();
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    pend_s.delete();
    nwr_s = 0;
  endtask

  // Present one beat (optionally with flush) and return at the negedge after it is accepted.
  task automatic send_s(input logic [7:0] b, input logic fl);
    int  w;
    logic ok;
    w = 0;
    valid_s = 1'b1;
    din_s   = b;
    flush_s = fl;
    while (!ready_s && w < 20) begin
      tick(1);
      w++;
    end
    ok = ready_s;
    check("ready_at_accept", 256'(ready_s), 256'(1));
    tick(1);
    flush_s = 1'b0;
    if (ok) begin
      model_beat(0, b);
      if (fl) model_flush_s();
    end
  endtask

  initial begin
    start_s = 0; flush_s = 0; valid_s = 0; din_s = '0;
    start_w = 0; flush_w = 0; valid_w = 0; din_w = '0;
    nwr_s = 0; nwr_w = 0;
    tick(2);
    check("rst_ready", 256'(ready_s), 256'(0));
    check("rst_we", 256'(we_s), 256'(0));
    check("rst_data", 256'(data_s), 256'(0));
    check("rst_addr", 256'(addr_s), 256'(0));
    check("rst_done", 256'(done_s), 256'(0));
    check("rst_wide_ready", 256'(ready_w), 256'(0));
    rst_n = 1'b1;
    tick(1);
    check("idle_ready", 256'(ready_s), 256'(0));
    start_s_pulse();
    check("start_ready", 256'(ready_s), 256'(1));
    check("start_we", 256'(we_s), 256'(0));
    check("start_done", 256'(done_s), 256'(0));

    // First word: one cycle after C3 is accepted.
    send_s(8'hA1, 1'b0);
    send_s(8'hB2, 1'b0);
    send_s(8'hC3, 1'b0);
    check("w1_we", 256'(we_s), 256'(2'b01));
    check("w1_data", 256'(data_s), 256'(20'hA1B2C));
    check("w1_addr", 256'(addr_s), 256'(0));

    // Remaining nine beats back-to-back fill both banks.
    for (int i = 0; i < 9; i++) begin
      check("no_bubble", 256'(ready_s), 256'(1));
      send_s(8'(8'h10 + i), 1'b0);
    end
    valid_s = 1'b0;
    check("last_we", 256'(we_s), 256'(2'b10));
    check("last_addr", 256'(addr_s), 256'(1));
    check("last_done_early", 256'(done_s), 256'(0));
    check("last_ready", 256'(ready_s), 256'(0));
    flush_s = 1'b1;
    tick(1);
    flush_s = 1'b0;
    check("done_set", 256'(done_s), 256'(1));
    check("done_ready", 256'(ready_s), 256'(0));
    tick(2);
    check("done_held", 256'(done_s), 256'(1));
    drain(0, "fill");

    // Restart, single-beat flush, then a start pulse in FILL that must be ignored.
    start_s_pulse();
    check("restart_done", 256'(done_s), 256'(0));
    check("restart_ready", 256'(ready_s), 256'(1));
    send_s(8'h5A, 1'b0);
    valid_s = 1'b0;
    flush_s = 1'b1;
    tick(1);
    flush_s = 1'b0;
    model_flush_s();
    check("flush_ready", 256'(ready_s), 256'(0));
    tick(1);
    check("flush_we", 256'(we_s), 256'(2'b01));
    check("flush_data", 256'(data_s), 256'(20'h5A000));
    check("flush_addr", 256'(addr_s), 256'(0));
    send_s(8'h11, 1'b0);
    valid_s = 1'b0;
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    send_s(8'h22, 1'b0);
    send_s(8'h33, 1'b0);
    valid_s = 1'b0;

    // Flush with nothing pending is a no-op.
    flush_s = 1'b1;
    tick(1);
    flush_s = 1'b0;
    model_flush_s();
    tick(3);
    drain(0, "flush");

    // Flush alongside a word-completing beat, then alongside a partial beat (final slot).
    send_s(8'h44, 1'b0);
    send_s(8'h55, 1'b0);
    send_s(8'h66, 1'b1);
    send_s(8'h77, 1'b0);
    send_s(8'h88, 1'b1);
    valid_s = 1'b0;
    tick(3);
    check("flush_done", 256'(done_s), 256'(1));
    drain(0, "flush_mix");

    // Reset in the middle of a word discards it.
    start_s_pulse();
    send_s(8'h9A, 1'b0);
    send_s(8'hBC, 1'b0);
    valid_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", 256'(data_s), 256'(0));
    check("arst_we", 256'(we_s), 256'(0));
    check("arst_ready", 256'(ready_s), 256'(0));
    check("arst_done", 256'(done_s), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pend_s.delete();
    nwr_s = 0;
    tick(2);
    drain(0, "reset");
    start_s_pulse();
    send_s(8'hDE, 1'b0);
    send_s(8'hAD, 1'b0);
    send_s(8'hBE, 1'b0);
    valid_s = 1'b0;
    tick(2);
    drain(0, "post_reset");

    // Wide instance: random beats with random valid gaps until all banks are full.
    start_w = 1'b1;
    tick(1);
    start_w = 1'b0;
    pend_w.delete();
    nwr_w = 0;
    for (int cyc = 0; cyc < 6000 && !done_w; cyc++) begin
      valid_w = ($urandom_range(0, 3) != 0);
      din_w   = 8'($urandom);
      if (valid_w && ready_w) model_beat(1, din_w);
      tick(1);
    end
    valid_w = 1'b0;
    check("wide_done", 256'(done_w), 256'(1));
    check("wide_words", 256'(nwr_w), 256'(NB_W * BD_W));
    tick(2);
    drain(1, "wide");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
